// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full adder plus a carry flop, LSB first.
// Operands are captured in the cycle after reset is released. The sum and
// carry-out are presented WIDTH+1 cycles later and held until the next reset.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             done
);

  localparam int unsigned   CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    LOAD,
    ADD,
    DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] ssum;
  logic [CW-1:0]  cnt;
  logic           carry;
  logic           s;
  logic           carry_next;
  logic           last_bit;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_next;
  end

  // Full adder on the operand LSBs, and next-state selection.
  always_comb begin
    state_next = state;
    s          = sa[0] ^ sb[0] ^ carry;
    carry_next = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
    last_bit   = (state == ADD) && (cnt == LAST);
    case (state)
      LOAD:    state_next = ADD;
      ADD:     if (last_bit) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
  end

  // Datapath: operand capture, shifting, and the result registers.
  // Outputs are written only on the final ADD cycle, so partial sums never
  // appear on out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa    <= '0;
      sb    <= '0;
      ssum  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      out   <= '0;
      cout  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          sa    <= data_a;
          sb    <= data_b;
          ssum  <= '0;
          cnt   <= '0;
          carry <= 1'b0;
        end
        ADD: begin
          sa    <= {1'b0, sa[WIDTH-1:1]};
          sb    <= {1'b0, sb[WIDTH-1:1]};
          ssum  <= {s, ssum[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
          carry <= carry_next;
          if (last_bit) begin
            out  <= {s, ssum[WIDTH-1:1]};
            cout <= carry_next;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] data_a = '0;
  logic [WIDTH-1:0] data_b = '0;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .data_a (data_a),
    .data_b (data_b),
    .out    (out),
    .cout   (cout),
    .done   (done)
  );

  // Reference: exact (WIDTH+1)-bit unsigned sum.
  function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Apply operands, pulse reset, release on a falling edge so the next
  // rising edge is edge 1 (LOAD).
  task automatic start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    data_a = a;
    data_b = b;
    reset  = 1'b0;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Advance n rising edges and settle just after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    data_a = 8'hAA;
    data_b = 8'h55;
    #3;
    total++;
    if ({done, cout, out} !== '0) begin
      bad++;
      $display("FAIL reset_async: got done=%b cout=%b out=%0d, want 0/0/0", done, cout, out);
    end
    edges(3);
    total++;
    if ({done, cout, out} !== '0) begin
      bad++;
      $display("FAIL reset_held: got done=%b cout=%b out=%0d, want 0/0/0", done, cout, out);
    end
  endtask

  task automatic test_basic;
    logic [WIDTH:0] exp;
    exp = ref_sum(8'd27, 8'd21);
    start(8'd27, 8'd21);
    for (int e = 1; e <= int'(WIDTH); e++) begin
      edges(1);
      total++;
      if ({done, cout, out} !== '0) begin
        bad++;
        $display("FAIL basic_early edge%0d: got done=%b cout=%b out=%0d, want 0/0/0",
                 e, done, cout, out);
      end
    end
    edges(1);
    total++;
    if (done !== 1'b1 || {cout, out} !== exp) begin
      bad++;
      $display("FAIL basic_result: got done=%b sum=%0d, want done=1 sum=%0d",
               done, {cout, out}, exp);
    end
  endtask

  task automatic test_corners;
    logic [WIDTH-1:0] ca [3];
    logic [WIDTH-1:0] cb [3];
    logic [WIDTH:0]   exp;
    ca = '{8'd255, 8'd255, 8'd0};
    cb = '{8'd1,   8'd255, 8'd0};
    for (int i = 0; i < 3; i++) begin
      exp = ref_sum(ca[i], cb[i]);
      start(ca[i], cb[i]);
      edges(WIDTH + 1);
      total++;
      if (done !== 1'b1 || cout !== exp[WIDTH] || out !== exp[WIDTH-1:0]) begin
        bad++;
        $display("FAIL corner %0d+%0d: got done=%b cout=%b out=%0d, want done=1 cout=%b out=%0d",
                 ca[i], cb[i], done, cout, out, exp[WIDTH], exp[WIDTH-1:0]);
      end
    end
  endtask

  task automatic test_input_change;
    logic [WIDTH:0] exp;
    exp = ref_sum(8'd27, 8'd21);
    start(8'd27, 8'd21);
    edges(4);
    data_a = 8'd100;
    data_b = 8'd100;
    edges(WIDTH + 1 - 4);
    total++;
    if (done !== 1'b1 || {cout, out} !== exp) begin
      bad++;
      $display("FAIL change_result: got done=%b sum=%0d, want done=1 sum=%0d",
               done, {cout, out}, exp);
    end
    for (int c = 0; c < 20; c++) begin
      data_a = 8'($urandom);
      data_b = 8'($urandom);
      edges(1);
      total++;
      if (done !== 1'b1 || {cout, out} !== exp) begin
        bad++;
        $display("FAIL done_hold cycle%0d: got done=%b sum=%0d, want done=1 sum=%0d",
                 c, done, {cout, out}, exp);
      end
    end
  endtask

  task automatic test_abort;
    logic [WIDTH:0] exp;
    exp = ref_sum(8'd200, 8'd100);
    start(8'd200, 8'd100);
    edges(5);
    reset = 1'b0;
    #1;
    total++;
    if ({done, cout, out} !== '0) begin
      bad++;
      $display("FAIL abort_clear: got done=%b cout=%b out=%0d, want 0/0/0", done, cout, out);
    end
    @(negedge clk);
    reset = 1'b1;
    edges(WIDTH);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL abort_early: got done=%b, want 0", done);
    end
    edges(1);
    total++;
    if (done !== 1'b1 || cout !== 1'b1 || out !== 8'd44) begin
      bad++;
      $display("FAIL abort_result: got done=%b cout=%b out=%0d, want done=1 cout=%b out=%0d",
               done, cout, out, exp[WIDTH], exp[WIDTH-1:0]);
    end
  endtask

  task automatic test_random;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   exp;
    for (int i = 0; i < 200; i++) begin
      a   = WIDTH'($urandom);
      b   = WIDTH'($urandom);
      exp = ref_sum(a, b);
      start(a, b);
      edges(WIDTH);
      total++;
      if (done !== 1'b0 || out !== '0) begin
        bad++;
        $display("FAIL rand_early %0d: got done=%b out=%0d, want done=0 out=0", i, done, out);
      end
      edges(1);
      total++;
      if (done !== 1'b1 || {cout, out} !== exp) begin
        bad++;
        $display("FAIL rand %0d+%0d: got done=%b sum=%0d, want done=1 sum=%0d",
                 a, b, done, {cout, out}, exp);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_corners;
    test_input_change;
    test_abort;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
